// File: rtl/mul_pkg.sv
// Shared multiplier datapath definitions: default product width and the
// redundant sum/carry pair handed from the compressor tree to the final adder.
package mul_pkg;

  localparam int MUL_W = 16;

  typedef struct packed {
    logic [MUL_W-1:0] sum;
    logic [MUL_W-1:0] carry;
  } sc_pair_t;

endpackage

// File: rtl/cpa_slice.sv
// H-bit ripple carry-propagate adder slice with carry in/out; purely combinational.
// No state, so no latency and no backpressure; the enclosing pipeline registers around it.
module cpa_slice
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W / 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule

// File: rtl/mul_cpa_pipe.sv
// Two-stage final CPA: low half resolved in s1, high half plus mid carry in s2; 2-cycle latency.
// Valid/ready on both sides, one result per cycle; in_ready follows out_ready combinationally.
module mul_cpa_pipe
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_cout
);

  localparam int H = W / 2;

  logic         s1_valid_q, s1_valid_d;
  logic [H-1:0] s1_lo_q, s1_lo_d;
  logic         s1_cmid_q, s1_cmid_d;
  logic [H-1:0] s1_sum_hi_q, s1_sum_hi_d;
  logic [H-1:0] s1_carry_hi_q, s1_carry_hi_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_prod_q, s2_prod_d;
  logic         s2_cout_q, s2_cout_d;

  logic         s2_ld;
  logic         s1_adv;
  logic         in_xfer;
  logic [H-1:0] lo_sum;
  logic         lo_cout;
  logic [H-1:0] hi_sum;
  logic         hi_cout;

  cpa_slice #(.WIDTH(H)) u_cpa_lo (
    .a    (in_sum[H-1:0]),
    .b    (in_carry[H-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cpa_slice #(.WIDTH(H)) u_cpa_hi (
    .a    (s1_sum_hi_q),
    .b    (s1_carry_hi_q),
    .cin  (s1_cmid_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // s2 can take new data whenever it is empty or being drained this cycle.
  assign s2_ld    = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ld;
  assign in_ready = !s1_valid_q || s2_ld;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_cmid_d     = s1_cmid_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    s2_valid_d    = s2_valid_q;
    s2_prod_d     = s2_prod_q;
    s2_cout_d     = s2_cout_q;

    if (in_xfer) begin
      s1_valid_d    = 1'b1;
      s1_lo_d       = lo_sum;
      s1_cmid_d     = lo_cout;
      s1_sum_hi_d   = in_sum[W-1:H];
      s1_carry_hi_d = in_carry[W-1:H];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_ld) begin
      s2_valid_d = s1_valid_q;
    end

    if (s1_adv) begin
      s2_prod_d = {hi_sum, s1_lo_q};
      s2_cout_d = hi_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_cmid_q     <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_prod_q     <= '0;
      s2_cout_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_cmid_q     <= s1_cmid_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      s2_valid_q    <= s2_valid_d;
      s2_prod_q     <= s2_prod_d;
      s2_cout_q     <= s2_cout_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_prod  = s2_prod_q;
  assign out_cout  = s2_cout_q;

endmodule
